// File: rtl/instruction_decode.sv
// ID stage of the 5-stage MIPS pipeline: register-file read addressing,
// instruction decode, load-use hazard detection and the ID/EX register.
module instruction_decode #(
  parameter int NB_DATA  = 32,
  parameter int NB_REG   = 5,
  parameter int NB_INSTR = 32,
  parameter int NB_PC    = 32,
  parameter int NB_ALUOP = 4
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic                valid_i,
  input  logic [NB_INSTR-1:0] instruction_i,
  input  logic [NB_PC-1:0]    pc_plus4_i,
  input  logic                flush_i,
  output logic [NB_REG-1:0]   addr_ra_o,
  output logic [NB_REG-1:0]   addr_rb_o,
  output logic                stall_o,
  output logic                valid_o,
  output logic [NB_REG-1:0]   rs_o,
  output logic [NB_REG-1:0]   rt_o,
  output logic [NB_REG-1:0]   rd_o,
  output logic [NB_DATA-1:0]  imm_ext_o,
  output logic [4:0]          shamt_o,
  output logic [NB_ALUOP-1:0] alu_op_o,
  output logic                alu_src_o,
  output logic                reg_write_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                mem_to_reg_o,
  output logic                branch_eq_o,
  output logic                branch_ne_o,
  output logic                jump_o,
  output logic                jump_reg_o,
  output logic                link_o,
  output logic [NB_PC-1:0]    branch_target_o,
  output logic [NB_PC-1:0]    jump_target_o,
  output logic [NB_PC-1:0]    pc_plus4_o,
  output logic                illegal_o
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04,
    OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C,
    OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F, OP_LW   = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR  = 6'h08,
    FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR  = 6'h25,
    FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A
  } funct_e;

  typedef enum logic [NB_ALUOP-1:0] {
    ALU_ADD = NB_ALUOP'(0), ALU_SUB = NB_ALUOP'(1), ALU_AND = NB_ALUOP'(2),
    ALU_OR  = NB_ALUOP'(3), ALU_XOR = NB_ALUOP'(4), ALU_NOR = NB_ALUOP'(5),
    ALU_SLT = NB_ALUOP'(6), ALU_SLL = NB_ALUOP'(7), ALU_SRL = NB_ALUOP'(8),
    ALU_SRA = NB_ALUOP'(9)
  } alu_e;

  typedef struct packed {
    logic                valid;
    logic [NB_REG-1:0]   rs;
    logic [NB_REG-1:0]   rt;
    logic [NB_REG-1:0]   rd;
    logic [NB_DATA-1:0]  imm;
    logic [4:0]          shamt;
    logic [NB_ALUOP-1:0] alu_op;
    logic                alu_src;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                branch_eq;
    logic                branch_ne;
    logic                jump;
    logic                jump_reg;
    logic                link;
    logic [NB_PC-1:0]    branch_target;
    logic [NB_PC-1:0]    jump_target;
    logic [NB_PC-1:0]    pc_plus4;
    logic                illegal;
  } idex_t;

  idex_t               r_ex;
  idex_t               w_dec;
  logic                w_legal;
  logic                w_wr;
  logic [5:0]          w_op;
  logic [5:0]          w_funct;
  logic [NB_REG-1:0]   w_rs;
  logic [NB_REG-1:0]   w_rt;
  logic [NB_DATA-1:0]  w_sext;
  logic [NB_DATA-1:0]  w_zext;
  logic [NB_PC-1:0]    w_boff;
  logic [NB_PC-1:0]    w_btgt;
  logic [NB_PC-1:0]    w_jtgt;
  logic                w_reads_rt;
  logic                w_load_use;
  logic                w_accept;

  assign w_op    = instruction_i[31:26];
  assign w_funct = instruction_i[5:0];
  assign w_rs    = instruction_i[25:21];
  assign w_rt    = instruction_i[20:16];
  assign w_sext  = {{(NB_DATA-16){instruction_i[15]}}, instruction_i[15:0]};
  assign w_zext  = {{(NB_DATA-16){1'b0}}, instruction_i[15:0]};
  assign w_boff  = {{(NB_PC-18){instruction_i[15]}}, instruction_i[15:0], 2'b00};
  assign w_btgt  = pc_plus4_i + w_boff;
  assign w_jtgt  = {pc_plus4_i[NB_PC-1 -: 4], instruction_i[25:0], 2'b00};

  assign addr_ra_o = w_rs;
  assign addr_rb_o = w_rt;

  // Load in EX whose destination feeds the instruction currently in ID
  assign w_reads_rt = (w_op == OP_RTYPE) || (w_op == OP_BEQ) ||
                      (w_op == OP_BNE)   || (w_op == OP_SW);
  assign w_load_use = r_ex.valid && r_ex.mem_read && (r_ex.rt != '0) && valid_i &&
                      ((r_ex.rt == w_rs) || ((r_ex.rt == w_rt) && w_reads_rt));
  assign stall_o    = w_load_use && !flush_i && enable_i;
  assign w_accept   = !flush_i && !w_load_use && valid_i;

  // Decode the IF/ID instruction into the next ID/EX contents
  always_comb begin
    w_dec          = '0;
    w_legal        = 1'b1;
    w_wr           = 1'b0;
    w_dec.valid    = 1'b1;
    w_dec.rs       = w_rs;
    w_dec.rt       = w_rt;
    w_dec.pc_plus4 = pc_plus4_i;
    case (w_op)
      OP_RTYPE: begin
        w_dec.rd    = instruction_i[15:11];
        w_dec.shamt = instruction_i[10:6];
        w_wr        = 1'b1;
        case (w_funct)
          FN_ADD:  w_dec.alu_op = ALU_ADD;
          FN_SUB:  w_dec.alu_op = ALU_SUB;
          FN_AND:  w_dec.alu_op = ALU_AND;
          FN_OR:   w_dec.alu_op = ALU_OR;
          FN_XOR:  w_dec.alu_op = ALU_XOR;
          FN_NOR:  w_dec.alu_op = ALU_NOR;
          FN_SLT:  w_dec.alu_op = ALU_SLT;
          FN_SLL:  w_dec.alu_op = ALU_SLL;
          FN_SRL:  w_dec.alu_op = ALU_SRL;
          FN_SRA:  w_dec.alu_op = ALU_SRA;
          FN_JR: begin
            w_dec.jump_reg = 1'b1;
            w_dec.rd       = '0;
            w_wr           = 1'b0;
          end
          default: w_legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_SLTI: begin
        w_dec.imm     = w_sext;
        w_dec.alu_src = 1'b1;
        w_dec.rd      = w_rt;
        w_wr          = 1'b1;
        w_dec.alu_op  = (w_op == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        w_dec.imm     = w_zext;
        w_dec.alu_src = 1'b1;
        w_dec.rd      = w_rt;
        w_wr          = 1'b1;
        w_dec.alu_op  = (w_op == OP_ANDI) ? ALU_AND :
                        (w_op == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_LUI: begin
        w_dec.imm     = {instruction_i[15:0], {(NB_DATA-16){1'b0}}};
        w_dec.alu_src = 1'b1;
        w_dec.rd      = w_rt;
        w_wr          = 1'b1;
      end
      OP_LW: begin
        w_dec.imm        = w_sext;
        w_dec.alu_src    = 1'b1;
        w_dec.mem_read   = 1'b1;
        w_dec.mem_to_reg = 1'b1;
        w_dec.rd         = w_rt;
        w_wr             = 1'b1;
      end
      OP_SW: begin
        w_dec.imm       = w_sext;
        w_dec.alu_src   = 1'b1;
        w_dec.mem_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        w_dec.imm           = w_sext;
        w_dec.alu_op        = ALU_SUB;
        w_dec.branch_eq     = (w_op == OP_BEQ);
        w_dec.branch_ne     = (w_op == OP_BNE);
        w_dec.branch_target = w_btgt;
      end
      OP_J: begin
        w_dec.jump        = 1'b1;
        w_dec.jump_target = w_jtgt;
      end
      OP_JAL: begin
        w_dec.jump        = 1'b1;
        w_dec.link        = 1'b1;
        w_dec.rd          = '1;
        w_wr              = 1'b1;
        w_dec.jump_target = w_jtgt;
      end
      default: w_legal = 1'b0;
    endcase
    w_dec.reg_write = w_wr && (w_dec.rd != '0);
    if (!w_legal) begin
      w_dec         = '0;
      w_dec.valid   = 1'b1;
      w_dec.illegal = 1'b1;
    end
  end

  // ID/EX register; reset and all bubble causes share the clear path,
  // and a disabled pipeline skips the update entirely to hold.
  always_ff @(posedge clock_i) begin
    if (reset_i || enable_i) begin
      r_ex <= (!reset_i && w_accept) ? w_dec : '0;
    end
  end

  assign valid_o         = r_ex.valid;
  assign rs_o            = r_ex.rs;
  assign rt_o            = r_ex.rt;
  assign rd_o            = r_ex.rd;
  assign imm_ext_o       = r_ex.imm;
  assign shamt_o         = r_ex.shamt;
  assign alu_op_o        = r_ex.alu_op;
  assign alu_src_o       = r_ex.alu_src;
  assign reg_write_o     = r_ex.reg_write;
  assign mem_read_o      = r_ex.mem_read;
  assign mem_write_o     = r_ex.mem_write;
  assign mem_to_reg_o    = r_ex.mem_to_reg;
  assign branch_eq_o     = r_ex.branch_eq;
  assign branch_ne_o     = r_ex.branch_ne;
  assign jump_o          = r_ex.jump;
  assign jump_reg_o      = r_ex.jump_reg;
  assign link_o          = r_ex.link;
  assign branch_target_o = r_ex.branch_target;
  assign jump_target_o   = r_ex.jump_target;
  assign pc_plus4_o      = r_ex.pc_plus4;
  assign illegal_o       = r_ex.illegal;

endmodule
